mem_data_port: RTL and testbench

MEM-stage data-memory port. It consumes the EX/MEM register outputs: word-aligned address, 2-bit byte offset, byte-enable mask, funct3 and store data. It runs the data-memory read/write handshake, stalls the pipeline until the access completes, shifts store data into byte-lane position, and extracts and sign/zero-extends load data for MEM/WB.

---
 rtl/mem_data_port.sv | 163 ++++++++++++++++
 tb/tb_mem_data_port.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_data_port.sv
// mem_data_port
// MEM-stage data-memory port. Takes a load/store from the EX/MEM register,
// issues it to data memory with registered request signals, stalls the
// pipeline until dmem_resp, lane-shifts store data and extends load data.
//
// Parameters:
//   ADDR_W : address width
//   DATA_W : data width (only 32 is supported)
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   req_read        : EX/MEM holds a load
//   req_write       : EX/MEM holds a store (never together with req_read)
//   addr            : word-aligned address
//   bit_shift       : byte offset within the word
//   funct3          : RV32I load/store width code
//   byte_enable     : store byte-lane mask, already offset-shifted
//   wdata           : unshifted store data
//   advance         : pipeline advancing this cycle
//   stall           : hold all pipeline registers
//   load_data       : extended load result
//   load_valid      : load_data valid (DONE after a read)
//   dmem_*          : registered data-memory request, read data and response
//   misalign_err    : only with MISALIGN_TRAP_EN; misaligned access trapped
//
// Optional feature macro: MISALIGN_TRAP_EN
module mem_data_port #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        bit_shift,
    input  logic [2:0]        funct3,
    input  logic [3:0]        byte_enable,
    input  logic [DATA_W-1:0] wdata,
    input  logic              advance,
    output logic              stall,
    output logic [DATA_W-1:0] load_data,
    output logic              load_valid,
    output logic [ADDR_W-1:0] dmem_address,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [3:0]        dmem_mbe,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_resp
`ifdef MISALIGN_TRAP_EN
    ,
    output logic              misalign_err
`endif
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q;
    logic [2:0]        funct3_q;
    logic [1:0]        shift_q;
    logic              is_read_q;
    logic              req;
    logic              misaligned;
    logic [DATA_W-1:0] rshift;
    logic [DATA_W-1:0] ext;

    assign req = req_read | req_write;

`ifdef MISALIGN_TRAP_EN
    // lw/sw need offset 0; halfwords must not straddle the word boundary.
    assign misaligned = ((funct3 == 3'b010) && (bit_shift != 2'd0)) ||
                        ((funct3[1:0] == 2'b01) && (bit_shift == 2'd3));
`else
    assign misaligned = 1'b0;
`endif

    // Gated by rst so every output reads 0 while reset is held.
    assign stall = ~rst & req & (state_q != StDone);

    // Lane extraction; halfword at offset 3 sees zeros shifted in as its upper byte.
    always_comb begin
        rshift = dmem_rdata >> {shift_q, 3'b000};
        case (funct3_q)
            3'b000:  ext = {{(DATA_W-8){rshift[7]}}, rshift[7:0]};
            3'b100:  ext = {{(DATA_W-8){1'b0}}, rshift[7:0]};
            3'b001:  ext = {{(DATA_W-16){rshift[15]}}, rshift[15:0]};
            3'b101:  ext = {{(DATA_W-16){1'b0}}, rshift[15:0]};
            default: ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            funct3_q     <= 3'b000;
            shift_q      <= 2'd0;
            is_read_q    <= 1'b0;
            load_data    <= '0;
            load_valid   <= 1'b0;
            dmem_address <= '0;
            dmem_read    <= 1'b0;
            dmem_write   <= 1'b0;
            dmem_mbe     <= 4'b0000;
            dmem_wdata   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req) begin
                        if (misaligned) begin
                            // Trapped: no memory access, straight to DONE.
                            state_q    <= StDone;
                            load_data  <= '0;
                            load_valid <= 1'b0;
                        end else begin
                            state_q      <= StBusy;
                            dmem_address <= addr;
                            dmem_mbe     <= req_read ? 4'b1111 : byte_enable;
                            dmem_wdata   <= wdata << {bit_shift, 3'b000};
                            dmem_read    <= req_read;
                            dmem_write   <= req_write;
                            funct3_q     <= funct3;
                            shift_q      <= bit_shift;
                            is_read_q    <= req_read;
                        end
                    end
                end
                StBusy: begin
                    if (dmem_resp) begin
                        dmem_read  <= 1'b0;
                        dmem_write <= 1'b0;
                        load_valid <= is_read_q;
                        if (is_read_q) begin
                            load_data <= ext;
                        end
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    // Hold here until the pipeline moves; never re-issue.
                    if (advance) begin
                        state_q    <= StIdle;
                        load_valid <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_err <= 1'b0;
        end else if ((state_q == StIdle) && req && misaligned) begin
            misalign_err <= 1'b1;
        end else if ((state_q == StDone) && advance) begin
            misalign_err <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_mem_data_port.sv
// Directed testbench for mem_data_port: loads of every width, stores with lane
// shifting, DONE hold behaviour, reset mid-access and (if built with
// MISALIGN_TRAP_EN) the misalignment trap.
module tb_mem_data_port;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_read = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] addr = '0;
    logic [1:0]  bit_shift = '0;
    logic [2:0]  funct3 = '0;
    logic [3:0]  byte_enable = '0;
    logic [31:0] wdata = '0;
    logic        advance = 1'b0;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic [31:0] dmem_address;
    logic        dmem_read;
    logic        dmem_write;
    logic [3:0]  dmem_mbe;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_resp = 1'b0;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    mem_data_port #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_read     (req_read),
        .req_write    (req_write),
        .addr         (addr),
        .bit_shift    (bit_shift),
        .funct3       (funct3),
        .byte_enable  (byte_enable),
        .wdata        (wdata),
        .advance      (advance),
        .stall        (stall),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .dmem_address (dmem_address),
        .dmem_read    (dmem_read),
        .dmem_write   (dmem_write),
        .dmem_mbe     (dmem_mbe),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp)
`ifdef MISALIGN_TRAP_EN
        ,
        .misalign_err (misalign_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Sample/drive point: 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Request inputs must already be set. Pulses dmem_resp in the resp_delay-th
    // cycle the request is visible, returns once stall drops.
    task automatic run_access(input int resp_delay, input logic [31:0] rdata,
                              output int stall_cycles, output logic rw_at_resp);
        int  busy_cnt;
        logic done;
        busy_cnt     = 0;
        stall_cycles = 0;
        rw_at_resp   = 1'b0;
        done         = 1'b0;
        #1;
        for (int c = 0; c < 40 && !done; c++) begin
            dmem_resp = 1'b0;
            #1;
            if (c > 0 && !stall) begin
                done = 1'b1;
            end else begin
                if (stall) stall_cycles++;
                if (dmem_read || dmem_write) busy_cnt++;
                if (busy_cnt == resp_delay) begin
                    dmem_resp  = 1'b1;
                    dmem_rdata = rdata;
                    rw_at_resp = dmem_read | dmem_write;
                end
                tick();
            end
        end
        dmem_resp = 1'b0;
        if (!done) check("access_timeout", 32'd1, 32'd0);
    endtask

    task automatic retire();
        advance   = 1'b1;
        req_read  = 1'b0;
        req_write = 1'b0;
        tick();
        advance = 1'b0;
    endtask

    task automatic load_case(input string tag, input logic [2:0] f3, input logic [1:0] sh,
                             input logic [31:0] rdata, input logic [31:0] exp);
        int   sc;
        logic rw;
        req_read  = 1'b1;
        addr      = 32'h0000_0100;
        funct3    = f3;
        bit_shift = sh;
        run_access(1, rdata, sc, rw);
        check({tag, "_data"}, load_data, exp);
        check({tag, "_valid"}, {31'd0, load_valid}, 32'd1);
        retire();
    endtask

    initial begin
        int   sc;
        logic rw;
        logic [31:0] held;

        // Reset: every output 0, stall suppressed even with a request pending.
        #1 rst = 1'b1;
        req_read = 1'b1;
        #1;
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_load_valid", {31'd0, load_valid}, 32'd0);
        check("rst_dmem_ctl", {28'd0, dmem_read, dmem_write, 2'b00}, 32'd0);
        check("rst_dmem_mbe", {28'd0, dmem_mbe}, 32'd0);
        check("rst_dmem_wdata", dmem_wdata, 32'd0);
        check("rst_dmem_addr", dmem_address, 32'd0);
        req_read = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // lb, offset 2, resp on the third request cycle: 4 stall cycles.
        req_read    = 1'b1;
        addr        = 32'h0000_0100;
        funct3      = 3'b000;
        bit_shift   = 2'd2;
        byte_enable = 4'b0001;
        run_access(3, 32'h0080_0000, sc, rw);
        check("lb_stall_cycles", sc, 32'd4);
        check("lb_data", load_data, 32'hFFFF_FF80);
        check("lb_valid", {31'd0, load_valid}, 32'd1);
        check("lb_read_cleared", {31'd0, dmem_read}, 32'd0);
        check("lb_mbe_forced", {28'd0, dmem_mbe}, 32'h0000_000F);
        check("lb_addr", dmem_address, 32'h0000_0100);
        retire();

        load_case("lhu", 3'b101, 2'd2, 32'hBEEF_1234, 32'h0000_BEEF);
        load_case("lw", 3'b010, 2'd0, 32'hBEEF_1234, 32'hBEEF_1234);
        load_case("lh", 3'b001, 2'd0, 32'h0000_8001, 32'hFFFF_8001);
        load_case("lbu", 3'b100, 2'd3, 32'h80FF_FFFF, 32'h0000_0080);
        load_case("undef_f3", 3'b111, 2'd1, 32'hCAFE_F00D, 32'hCAFE_F00D);
`ifndef MISALIGN_TRAP_EN
        load_case("lh_off3", 3'b001, 2'd3, 32'hFF00_0000, 32'h0000_00FF);
`endif

        // sb at offset 1: lane shift, mask passed through, write held to resp.
        req_write   = 1'b1;
        addr        = 32'h0000_0200;
        funct3      = 3'b000;
        bit_shift   = 2'd1;
        byte_enable = 4'b0010;
        wdata       = 32'h0000_00AB;
        run_access(2, 32'h0, sc, rw);
        check("sb_wdata", dmem_wdata, 32'h0000_AB00);
        check("sb_mbe", {28'd0, dmem_mbe}, 32'h0000_0002);
        check("sb_write_at_resp", {31'd0, rw}, 32'd1);
        check("sb_write_cleared", {31'd0, dmem_write}, 32'd0);
        check("sb_stall_cycles", sc, 32'd3);
        check("sb_no_valid", {31'd0, load_valid}, 32'd0);
        retire();

        // sh at offset 2 truncates nothing; wdata upper bits shift out.
        req_write   = 1'b1;
        funct3      = 3'b001;
        bit_shift   = 2'd2;
        byte_enable = 4'b1100;
        wdata       = 32'h1234_5678;
        run_access(1, 32'h0, sc, rw);
        check("sh_wdata", dmem_wdata, 32'h5678_0000);
        retire();

        // DONE hold: 5 cycles without advance, no re-issue.
        req_read  = 1'b1;
        addr      = 32'h0000_0100;
        funct3    = 3'b010;
        bit_shift = 2'd0;
        run_access(1, 32'h1234_5678, sc, rw);
        held = load_data;
        check("hold_data_first", held, 32'h1234_5678);
        for (int i = 0; i < 5; i++) begin
            check("hold_no_reissue", {31'd0, dmem_read}, 32'd0);
            check("hold_data", load_data, held);
            check("hold_stall", {31'd0, stall}, 32'd0);
            tick();
        end
        advance = 1'b1;
        addr    = 32'h0000_0300;
        tick();
        advance = 1'b0;
        check("adv_idle_no_read", {31'd0, dmem_read}, 32'd0);
        check("adv_valid_clear", {31'd0, load_valid}, 32'd0);
        check("adv_data_kept", load_data, 32'h1234_5678);
        check("adv_idle_stall", {31'd0, stall}, 32'd1);
        tick();
        check("adv_read_rises", {31'd0, dmem_read}, 32'd1);
        check("adv_new_addr", dmem_address, 32'h0000_0300);

        // Reset while BUSY: read and stall drop at once.
        rst = 1'b1;
        #1;
        check("midrst_read", {31'd0, dmem_read}, 32'd0);
        check("midrst_stall", {31'd0, stall}, 32'd0);
        check("midrst_data", load_data, 32'd0);
        tick();
        req_read = 1'b0;
        rst      = 1'b0;
        tick();
        // Late response in IDLE is ignored.
        dmem_rdata = 32'hFFFF_FFFF;
        dmem_resp  = 1'b1;
        tick();
        dmem_resp = 1'b0;
        tick();
        check("late_resp_valid", {31'd0, load_valid}, 32'd0);
        check("late_resp_data", load_data, 32'd0);
        check("late_resp_read", {31'd0, dmem_read}, 32'd0);
        load_case("post_rst_lw", 3'b010, 2'd0, 32'h0BAD_F00D, 32'h0BAD_F00D);

`ifdef MISALIGN_TRAP_EN
        // Misaligned lw: no memory access, trap flag in DONE until advance.
        req_read  = 1'b1;
        funct3    = 3'b010;
        bit_shift = 2'd1;
        tick();
        #1;
        check("mis_no_read", {31'd0, dmem_read}, 32'd0);
        check("mis_err", {31'd0, misalign_err}, 32'd1);
        check("mis_valid", {31'd0, load_valid}, 32'd0);
        check("mis_data", load_data, 32'd0);
        check("mis_stall", {31'd0, stall}, 32'd0);
        #1;
        retire();
        check("mis_err_clear", {31'd0, misalign_err}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
